// File: rtl/load_register.sv
// ============================================================================
// Module   : load_register
// Brief    : Single-word load-enabled storage register with async active-low
//            reset. Optional shadow outputs (prev/changed) are enabled by
//            defining LOAD_REGISTER_SHADOW_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_register #(
    parameter int          WIDTH       = 16,
    parameter logic [63:0] RESET_VALUE = 64'd0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
`ifdef LOAD_REGISTER_SHADOW_EN
    output logic [WIDTH-1:0] prev,
    output logic             changed,
`endif
    output logic [WIDTH-1:0] out
);

    localparam logic [WIDTH-1:0] C_RST = RESET_VALUE[WIDTH-1:0];

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // A non-1 load (including X) falls into the hold branch.
    always_comb begin
        data_d = data_q;
        if (load == 1'b1) begin
            data_d = in;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= C_RST;
        end else begin
            data_q <= data_d;
        end
    end

    assign out = data_q;

`ifdef LOAD_REGISTER_SHADOW_EN
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;
    logic             changed_q;
    logic             changed_d;

    always_comb begin
        prev_d    = prev_q;
        changed_d = 1'b0;
        if (load == 1'b1) begin
            prev_d    = data_q;
            changed_d = (in != data_q);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_q    <= C_RST;
            changed_q <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            changed_q <= changed_d;
        end
    end

    assign prev    = prev_q;
    assign changed = changed_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_load_register.sv
// ============================================================================
// Module   : tb_load_register
// Brief    : Randomized self-checking bench for load_register against a
//            behavioural storage model (shadow checks with LOAD_REGISTER_SHADOW_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_register;

    localparam int C_W = 16;

    logic           clock;
    logic           reset_n;
    logic [C_W-1:0] r_in;
    logic           r_load;
    logic [C_W-1:0] w_out;
`ifdef LOAD_REGISTER_SHADOW_EN
    logic [C_W-1:0] w_prev;
    logic           w_changed;
`endif

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: the stored word, the word before the last load, and
    // whether the last edge was a value-changing load.
    logic [C_W-1:0] m_val  = '0;
    logic [C_W-1:0] m_prev = '0;
    logic           m_chg  = 1'b0;

    load_register #(
        .WIDTH       (C_W),
        .RESET_VALUE (64'd0)
    ) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .in      (r_in),
        .load    (r_load),
`ifdef LOAD_REGISTER_SHADOW_EN
        .prev    (w_prev),
        .changed (w_changed),
`endif
        .out     (w_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_val  = '0;
        m_prev = '0;
        m_chg  = 1'b0;
    endtask

    task automatic model_edge(input logic [C_W-1:0] in_v, input logic load_v);
        if (load_v) begin
            m_chg  = (in_v != m_val);
            m_prev = m_val;
            m_val  = in_v;
        end else begin
            m_chg = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        check(tag, {48'd0, w_out}, {48'd0, m_val});
`ifdef LOAD_REGISTER_SHADOW_EN
        check({tag, "_prev"}, {48'd0, w_prev}, {48'd0, m_prev});
        check({tag, "_chg"}, {63'd0, w_changed}, {63'd0, m_chg});
`endif
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input string tag, input logic [C_W-1:0] in_v, input logic load_v);
        @(negedge clock);
        r_in   = in_v;
        r_load = load_v;
        @(posedge clock);
        #1;
        model_edge(in_v, load_v);
        check_all(tag);
    endtask

    task automatic mid_cycle_reset();
        @(negedge clock);
        r_in   = 16'hFFFF;
        r_load = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clock);
        #1;
        check_all("rst_held");
        @(negedge clock);
        reset_n = 1'b1;
        r_load  = 1'b0;
    endtask

    initial begin
        logic [C_W-1:0] rnd_in;
        reset_n = 1'b0;
        r_in    = 16'hFFFF;
        r_load  = 1'b1;

        // Reset dominates load for several edges.
        repeat (3) begin
            @(posedge clock);
            #1;
            check_all("rst_hold");
        end
        @(negedge clock);
        reset_n = 1'b1;
        r_load  = 1'b0;
        step("post_rst", 16'h5555, 1'b0);

        // Capture timing: in changes after the edge must not reach out.
        step("cap", 16'h1234, 1'b1);
        r_in   = 16'hABCD;
        r_load = 1'b0;
        #1;
        check_all("no_comb");
        @(posedge clock);
        #1;
        model_edge(16'hABCD, 1'b0);
        check_all("cap_hold");

        // Alternating load/hold with an incrementing word.
        for (int i = 0; i < 8; i++) begin
            step("alt", 16'h0100 + 16'(i), (i % 2) == 0);
        end

        // Asynchronous reset between edges.
        step("pre_rst", 16'h00AA, 1'b1);
        mid_cycle_reset();

        // Back-to-back loads then hold.
        for (int i = 1; i <= 4; i++) begin
            step("b2b", 16'(i), 1'b1);
        end
        step("b2b_hold", 16'h0009, 1'b0);

        // Shadow scenario: change, no-load, same-value reload.
        step("sh5", 16'h0005, 1'b1);
        step("sh7", 16'h0007, 1'b1);
        step("sh_idle", 16'h0007, 1'b0);
        step("sh_same", 16'h0007, 1'b1);

        // Random traffic with occasional mid-cycle resets and same-value loads.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                mid_cycle_reset();
            end else begin
                rnd_in = ($urandom_range(0, 3) == 0) ? m_val : C_W'($urandom);
                step("rand", rnd_in, 1'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
